pwm_vnb: RTL and testbench

PWM_VNB -- requirements
Module: pwm_vnb

---
 rtl/pwm_vnb_pkg.sv | 17 +
 rtl/pwm_vnb_cnt.sv | 51 +++++
 rtl/pwm_vnb.sv | 112 +++++++++++
 tb/tb_pwm_vnb.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_vnb_pkg.sv
// -----------------------------------------------------------------------------
// pwm_vnb_pkg
// Shared constants for the pwm_vnb PWM generator and its period counter.
//   CNT_W_DEF : default counter / duty width
//   CNT_MAX   : terminal count of the default-width counter
//   cnt_max_f : terminal (all-ones) count for an arbitrary counter width
// -----------------------------------------------------------------------------
package pwm_vnb_pkg;

  function automatic int unsigned cnt_max_f(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int CNT_W_DEF = 4;
  localparam int CNT_MAX   = 15;

endpackage

// File: rtl/pwm_vnb_cnt.sv
// -----------------------------------------------------------------------------
// pwm_vnb_cnt
// Free-running enabled up-counter that wraps at its all-ones value, with a
// combinational terminal-count flag decoded from the registered count.
// Ports:
//   clk   in  : clock, rising edge
//   rst_n in  : asynchronous active-low reset (count -> 0)
//   ce    in  : count enable; count holds when low
//   cnt   out : current (registered) count
//   tc    out : high while cnt is at its terminal value
// -----------------------------------------------------------------------------
module pwm_vnb_cnt
  import pwm_vnb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(cnt_max_f(CNT_W));

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: increment with natural wrap when enabled, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (ce) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == TC_VAL);

endmodule

// File: rtl/pwm_vnb.sv
// -----------------------------------------------------------------------------
// pwm_vnb
// PWM generator with a 2**CNT_W-clock period. PWM is high while the period
// counter is below the effective duty; Chk marks the clock after each wrap.
// Optional feature: define PWM_VNB_SHADOW_EN to latch the duty code only at
// period boundaries (the first period after reset then runs with duty 0).
// Without it, the duty inputs feed the compare directly.
// Ports:
//   CLK        in  : clock, rising edge
//   RST_N      in  : asynchronous active-low reset
//   CE         in  : count enable; all state holds when low
//   D0..D3     in  : duty code {D3,D2,D1,D0}, D0 = LSB
//   PWM        out : registered PWM output
//   Chk        out : registered one-clock period-marker pulse
// -----------------------------------------------------------------------------
module pwm_vnb
  import pwm_vnb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CE,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  output logic PWM,
  output logic Chk
);

  logic [3:0]       duty_raw_s;
  logic [CNT_W-1:0] duty_in_s;
  logic [CNT_W-1:0] duty_eff_s;
  logic [CNT_W-1:0] cnt_s;
  logic             tc_s;

  logic pwm_d;
  logic pwm_q;
  logic chk_d;
  logic chk_q;

  // The duty port list is fixed at four bits; it is resized to the counter.
  assign duty_raw_s = {D3, D2, D1, D0};
  assign duty_in_s  = CNT_W'(duty_raw_s);

  pwm_vnb_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .ce    (CE),
    .cnt   (cnt_s),
    .tc    (tc_s)
  );

`ifdef PWM_VNB_SHADOW_EN
  logic [CNT_W-1:0] duty_d;
  logic [CNT_W-1:0] duty_q;

  // Shadow duty: reload only on the enabled edge that closes a period.
  always_comb begin
    duty_d = duty_q;
    if (CE && tc_s) begin
      duty_d = duty_in_s;
    end else begin
      duty_d = duty_q;
    end
  end

  // Shadow duty register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      duty_q <= {CNT_W{1'b0}};
    end else begin
      duty_q <= duty_d;
    end
  end

  assign duty_eff_s = duty_q;
`else
  assign duty_eff_s = duty_in_s;
`endif

  // Compare uses the pre-increment count; Chk only fires on an enabled wrap.
  always_comb begin
    pwm_d = pwm_q;
    chk_d = 1'b0;
    if (CE) begin
      pwm_d = (cnt_s < duty_eff_s);
      chk_d = tc_s;
    end else begin
      pwm_d = pwm_q;
      chk_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pwm_q <= 1'b0;
      chk_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
      chk_q <= chk_d;
    end
  end

  assign PWM = pwm_q;
  assign Chk = chk_q;

endmodule

// File: tb/tb_pwm_vnb.sv
// -----------------------------------------------------------------------------
// tb_pwm_vnb
// Self-checking bench for pwm_vnb: a table of duty codes with hand-computed
// per-window counts, followed by directed sequences for enable hold, enable
// low at the terminal count, and mid-period duty change. Expectations follow
// PWM_VNB_SHADOW_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_pwm_vnb;

`ifdef PWM_VNB_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b1;
  logic [3:0] d = 4'b0000;
  logic       pwm;
  logic       chk;

  int n_cmp  = 0;
  int n_fail = 0;

  pwm_vnb dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .CE    (ce),
    .D0    (d[0]),
    .D1    (d[1]),
    .D2    (d[2]),
    .D3    (d[3]),
    .PWM   (pwm),
    .Chk   (chk)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic [3:0] duty;
    int         exp_high_plain;   // PWM-high samples in 32 clocks, direct duty
    int         exp_high_shadow;  // same with shadowed duty (first period at 0)
    int         exp_chk;          // Chk pulses in 32 clocks
    int         exp_first_chk;    // clock index of the first Chk pulse
  } vec_t;

  vec_t vecs[5];

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, check outputs clear at once, release at negedge.
  task automatic do_reset(input logic [3:0] duty);
    rst_n = 1'b0;
    #1;
    check_bit("rst_async_pwm", pwm, 1'b0);
    check_bit("rst_async_chk", chk, 1'b0);
    d  = duty;
    ce = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int hi;
    int per;
    int chks;
    int first;
    int pwm_at_chk;
    int frozen;
    int n;
    bit found;

    vecs[0] = '{4'b1111, 30, 15, 2, 16};
    vecs[1] = '{4'b0000,  0,  0, 2, 16};
    vecs[2] = '{4'b0101, 10,  5, 2, 16};
    vecs[3] = '{4'b0001,  2,  1, 2, 16};
    vecs[4] = '{4'b1000, 16,  8, 2, 16};

    #20;

    // Table: each vector restarts from reset and watches 32 enabled clocks.
    for (int v = 0; v < 5; v++) begin
      do_reset(vecs[v].duty);
      hi = 0; chks = 0; first = 0; pwm_at_chk = 0;
      for (int k = 1; k <= 32; k++) begin
        tick();
        if (pwm) hi++;
        if (chk) begin
          chks++;
          if (first == 0) first = k;
          if (pwm) pwm_at_chk++;
        end
      end
      check_int("vec_pwm_high", hi,
                SHADOW ? vecs[v].exp_high_shadow : vecs[v].exp_high_plain);
      check_int("vec_chk_count", chks, vecs[v].exp_chk);
      check_int("vec_first_chk", first, vecs[v].exp_first_chk);
      check_int("vec_pwm_low_at_chk", pwm_at_chk, 0);
      // Leave the counter mid-period so the next reset aborts a live period.
      repeat (3) tick();
    end

    // Enable hold for 7 clocks mid-period stretches the period to 23 clocks.
    do_reset(4'b0101);
    repeat (16) tick();
    hi = 0; per = 0;
    repeat (3) begin
      tick(); per++;
      if (pwm) hi++;
    end
    check_int("hold_pre_high", hi, 3);
    check_bit("hold_pre_pwm", pwm, 1'b1);
    ce = 1'b0;
    frozen = 0; chks = 0;
    repeat (7) begin
      tick(); per++;
      if (pwm) frozen++;
      if (chk) chks++;
    end
    check_int("hold_pwm_frozen", frozen, 7);
    check_int("hold_chk_low", chks, 0);
    ce = 1'b1;
    n = 0; found = 1'b0; hi = 0;
    while (!found && n < 40) begin
      tick(); n++; per++;
      if (pwm) hi++;
      if (chk) found = 1'b1;
    end
    check_int("hold_period_len", per, 23);
    check_int("hold_post_high", hi, 2);

    // Enable low exactly at the terminal count must suppress Chk.
    repeat (15) tick();
    ce = 1'b0;
    tick();
    check_bit("tc_ce_low_chk", chk, 1'b0);
    ce = 1'b1;
    tick();
    check_bit("tc_ce_high_chk", chk, 1'b1);
    tick();
    check_bit("tc_after_chk", chk, 1'b0);

    // Duty 3 -> 12 at count 6.
    do_reset(4'b0011);
    repeat (16) tick();
    hi = 0;
    repeat (6) begin
      tick();
      if (pwm) hi++;
    end
    d = 4'b1100;
    tick();
    if (pwm) hi++;
    check_bit("shadow_next_edge", pwm, SHADOW ? 1'b0 : 1'b1);
    repeat (9) begin
      tick();
      if (pwm) hi++;
    end
    check_int("shadow_cur_period", hi, SHADOW ? 3 : 9);
    check_bit("shadow_period_end_chk", chk, 1'b1);
    hi = 0;
    repeat (16) begin
      tick();
      if (pwm) hi++;
    end
    check_int("shadow_next_period", hi, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
